// File: rtl/instr_dispatch.sv
// instr_dispatch: buffers received instructions and issues them one at a time,
// requesting a register-file dump after each retire or retire timeout.
module instr_dispatch #(
    parameter int DEPTH          = 4,
    parameter int RETIRE_TIMEOUT = 1023
) (
    input  logic                   clk12,
    input  logic                   rst,
    input  logic [31:0]            instruction,
    input  logic                   instruction_rcv,
    output logic [31:0]            instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   retired,
    output logic                   do_write,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(RETIRE_TIMEOUT + 1);

    typedef enum logic [2:0] {DUMP_REQ, DUMP_WAIT, IDLE, ISSUE, EXEC} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] timer;
    logic          rcv_q, txr_q;
    logic          push, pop, full, push_ok, tx_fall;

    assign push        = instruction_rcv & ~rcv_q;
    assign tx_fall     = ~tx_ready & txr_q;
    assign full        = count == (AW+1)'(DEPTH);
    assign pop         = instr_valid & instr_ready;
    // a full FIFO still takes a word when the head leaves in the same cycle
    assign push_ok     = push & (~full | pop);
    assign instr_valid = state == ISSUE;
    assign do_write    = state == DUMP_REQ;
    assign instr_out   = mem[rd_ptr];

    always_ff @(posedge clk12)
        if (push_ok) mem[wr_ptr] <= instruction;

    always_ff @(posedge clk12) begin
        rcv_q <= instruction_rcv;
        txr_q <= tx_ready;
        if (rst) begin
            state    <= DUMP_REQ;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            timer    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (push & ~push_ok) overflow <= 1'b1;
            case (state)
                IDLE:      if (count != '0) state <= ISSUE;
                ISSUE:     if (instr_ready) begin
                    state <= EXEC;
                    timer <= TW'(RETIRE_TIMEOUT);
                end
                EXEC: begin
                    timer <= timer - 1'b1;
                    // a retire on the final timer cycle wins over the timeout
                    if (retired) state <= DUMP_REQ;
                    else if (timer == '0) begin
                        timeout <= 1'b1;
                        state   <= DUMP_REQ;
                    end
                end
                DUMP_REQ:  if (tx_ready) state <= DUMP_WAIT;
                DUMP_WAIT: if (tx_fall) state <= IDLE;
                default:   state <= DUMP_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_dispatch.sv
// tb_instr_dispatch: drives instr_dispatch with a tx_regfile model and checks
// issued words against a scoreboard plus cycle-exact timing of dumps.
module tb_instr_dispatch;
    logic        clk12 = 0, rst = 1;
    logic [31:0] instruction = '0, instr_out;
    logic        instruction_rcv = 0, instr_ready = 0, retired = 0, tx_ready = 0;
    logic        instr_valid, do_write, overflow, timeout;
    logic [2:0]  count;
    int          checks = 0, failures = 0, dumps = 0, tcnt = 0, dump_len = 40;
    logic [31:0] sb [$];

    typedef struct {
        logic [31:0] word;
        int          ret_delay;
        logic [31:0] exp_out;
        logic        exp_dw;
    } vec_t;
    vec_t vecs [6];

    instr_dispatch #(.DEPTH(4), .RETIRE_TIMEOUT(8)) dut (
        .clk12(clk12), .rst(rst), .instruction(instruction),
        .instruction_rcv(instruction_rcv), .instr_out(instr_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .retired(retired),
        .do_write(do_write), .tx_ready(tx_ready), .count(count),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk12 = ~clk12;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock: score an accept, step the tx_regfile model, then advance past the edge.
    task automatic tick();
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL issue_unexpected actual=%h expected=none", instr_out);
            end else chk("issue_order", instr_out, sb.pop_front());
        end
        if (rst) begin
            tx_ready = 0;
            tcnt = 0;
        end else if (tx_ready) begin
            tcnt++;
            if (tcnt >= dump_len) begin
                tx_ready = 0;
                tcnt = 0;
                dumps++;
            end
        end else if (do_write) begin
            tcnt++;
            if (tcnt >= 3) begin
                tx_ready = 1;
                tcnt = 0;
            end
        end
        @(posedge clk12);
        #1;
    endtask

    task automatic push1(input logic [31:0] w, input logic acc);
        instruction = w;
        instruction_rcv = 1;
        if (acc) sb.push_back(w);
        tick();
        instruction_rcv = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin
            tick();
            n++;
        end
        chk("wait_valid", 32'(instr_valid), 1);
    endtask

    task automatic wait_dump();
        int n0 = dumps, n = 0;
        while (dumps == n0 && n < 300) begin
            tick();
            n++;
        end
        chk("dump_done", 32'(dumps != n0), 1);
    endtask

    initial begin
        vecs[0] = '{32'h11111111, 0, 32'h11111111, 1'b1};
        vecs[1] = '{32'h22222222, 1, 32'h22222222, 1'b1};
        vecs[2] = '{32'h33333333, 2, 32'h33333333, 1'b1};
        vecs[3] = '{32'h44444444, 7, 32'h44444444, 1'b1};
        vecs[4] = '{32'h55555555, 3, 32'h55555555, 1'b1};
        vecs[5] = '{32'h66666666, 0, 32'h66666666, 1'b1};

        repeat (3) tick();
        rst = 0;
        chk("rst_do_write", 32'(do_write), 1);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_timeout", 32'(timeout), 0);

        for (int i = 0; i < 3; i++) begin
            chk("dump_req_hold", 32'(do_write), 1);
            tick();
        end
        chk("dump_req_drop", 32'(do_write), 0);
        chk("dump_tx_ready", 32'(tx_ready), 1);
        wait_dump();
        chk("idle_do_write", 32'(do_write), 0);
        chk("idle_valid", 32'(instr_valid), 0);
        chk("idle_count", 32'(count), 0);
        tick();
        chk("idle_stays", 32'(do_write), 0);

        dump_len = 4;
        instr_ready = 1;
        push1(32'h00500093, 1);
        chk("single_count", 32'(count), 1);
        chk("single_valid_n1", 32'(instr_valid), 0);
        tick();
        chk("single_valid_n2", 32'(instr_valid), 1);
        chk("single_out", instr_out, 32'h00500093);
        tick();
        chk("single_count_after", 32'(count), 0);
        chk("single_exec_valid", 32'(instr_valid), 0);
        repeat (4) tick();
        chk("single_exec_no_dump", 32'(do_write), 0);
        retired = 1;
        tick();
        retired = 0;
        chk("single_retire_dump", 32'(do_write), 1);
        wait_dump();

        foreach (vecs[i]) begin
            push1(vecs[i].word, 0);
            sb.push_back(vecs[i].exp_out);
            wait_valid();
            tick();
            repeat (vecs[i].ret_delay) tick();
            retired = 1;
            tick();
            retired = 0;
            chk("wrap_retire_dump", 32'(do_write), 32'(vecs[i].exp_dw));
            wait_dump();
        end
        chk("wrap_sb_empty", sb.size(), 0);

        push1(32'hC0DE0001, 1);
        wait_valid();
        tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("ret0_exec", 32'(do_write), 0);
        end
        retired = 1;
        tick();
        retired = 0;
        chk("ret0_dump", 32'(do_write), 1);
        chk("ret0_no_timeout", 32'(timeout), 0);
        wait_dump();

        push1(32'hC0DE0002, 1);
        wait_valid();
        tick();
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("timeout_dump_at", 32'(do_write), 32'(i == 9));
            chk("timeout_flag_at", 32'(timeout), 32'(i == 9));
        end
        wait_dump();
        chk("timeout_sticky", 32'(timeout), 1);

        instr_ready = 0;
        for (int i = 0; i < 5; i++) begin
            push1(32'hF0000000 + i, i < 4);
            tick();
        end
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", instr_out, 32'hF0000000);
        instr_ready = 1;
        instruction = 32'hAAAAAAAA;
        instruction_rcv = 1;
        sb.push_back(32'hAAAAAAAA);
        tick();
        instruction_rcv = 0;
        chk("ovf_pushpop_count", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            retired = 1;
            tick();
            retired = 0;
            wait_dump();
            wait_valid();
            tick();
        end
        retired = 1;
        tick();
        retired = 0;
        wait_dump();
        chk("ovf_drained", sb.size(), 0);
        chk("ovf_count_end", 32'(count), 0);

        push1(32'h0BADF00D, 1);
        wait_valid();
        tick();
        retired = 1;
        tick();
        retired = 0;
        dump_len = 40;
        for (int n = 0; n < 20 && !tx_ready; n++) tick();
        chk("mid_in_wait", 32'(do_write), 0);
        chk("mid_tx_ready", 32'(tx_ready), 1);
        push1(32'h22220001, 0);
        tick();
        instruction = 32'h22220002;
        instruction_rcv = 1;
        tick();
        chk("mid_count", 32'(count), 2);
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_do_write", 32'(do_write), 1);
        chk("mid_rst_valid", 32'(instr_valid), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        chk("mid_rst_timeout", 32'(timeout), 0);
        dump_len = 4;
        repeat (2) begin
            tick();
            chk("mid_no_push", 32'(count), 0);
        end
        wait_dump();
        chk("mid_idle_valid", 32'(instr_valid), 0);
        chk("mid_idle_count", 32'(count), 0);
        instruction_rcv = 0;
        tick();
        chk("final_count", 32'(count), 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_dispatch.md
# instr_dispatch

Buffers 32-bit instructions from `rx_instruction` and hands them one at a time to the core over a valid/ready handshake. After each instruction retires, or after a retire timeout, it triggers `tx_regfile` to send the register file back over UART. It sits between the UART receive path and the core on the instruction side, and drives `do_write` into the transmit path. After reset it requests one initial register-file dump before issuing anything.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RETIRE_TIMEOUT`, 1023: cycles allowed in EXEC before a forced dump; ≥1.

Ports (clock and reset first):
- `clk12`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `instruction`  in  32  word from `rx_instruction`; valid while `instruction_rcv` is high.
- `instruction_rcv`  in  1  receive flag from `rx_instruction`; only its rising edge is significant.
- `instr_out`  out  32  FIFO head word.
- `instr_valid`  out  1  high in ISSUE.
- `instr_ready`  in  1  core accepts `instr_out`.
- `retired`  in  1  one-cycle pulse from the core when the issued instruction completes.
- `do_write`  out  1  request to `tx_regfile`.
- `tx_ready`  in  1  `tx_regfile` `ready`; high while a dump is in progress, falls at completion.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `timeout`  out  1  sticky: at least one forced dump has occurred.

## Operation
**Edge detect**
- `rcv_q` registers `instruction_rcv`; push = `instruction_rcv & ~rcv_q`.
- `txr_q` registers `tx_ready`; `tx_fall` = `~tx_ready & txr_q`.
- During `rst`, `rcv_q` and `txr_q` load the current input value, so an input held high through reset causes no event.

**FIFO**
- Circular buffer with `wr_ptr`/`rd_ptr` of width $clog2(DEPTH), wrapping modulo DEPTH.
- Push writes `instruction` at `wr_ptr`.
- Pop happens on `instr_valid & instr_ready`.
- Full is judged on the pre-pop count:
  - full and push, no pop: word dropped, `overflow` set, count unchanged.
  - full, push and pop in the same cycle: push accepted, count unchanged.
- Empty and pop cannot occur, because `instr_valid` requires non-empty.

**FSM** (reset state DUMP_REQ)
- IDLE: if `count != 0`, go to ISSUE.
- ISSUE: `instr_valid = 1`. On `instr_ready`: pop, load timer with RETIRE_TIMEOUT, go to EXEC.
- EXEC: timer decrements every cycle.
  - `retired`: go to DUMP_REQ.
  - otherwise, timer == 0: set `timeout`, go to DUMP_REQ.
  - `retired` in the same cycle the timer reaches 0: counts as a retire; `timeout` not set.
- DUMP_REQ: `do_write = 1`. When `tx_ready` is sampled high, go to DUMP_WAIT.
- DUMP_WAIT: `do_write = 0`. On `tx_fall`, go to IDLE.
- `retired` outside EXEC is ignored.
- Pushes are accepted in every state.

**Reset**
- Reset mid-operation (any state, including a dump in flight) clears the FIFO, pointers and sticky flags, and returns the FSM to DUMP_REQ.
- The core and `tx_regfile` are reset by the same `rst`.

## Timing
- Reset values: `instr_valid` 0, `count` 0, `overflow` 0, `timeout` 0, `instr_out` undefined (don't-care while `instr_valid` is 0).
- `do_write` is 1 in the first cycle after reset, because the FSM starts in DUMP_REQ.
- `instr_valid` and `do_write` are decoded from the state register only; no combinational path from inputs.
- Push latency:
  - `instruction_rcv` sampled rising in cycle N → `count` increments at N+1.
  - From IDLE: ISSUE and `instr_valid` high at N+2.
- `instr_out` equals the head entry, stable while `instr_valid` is high.
- Back-to-back issue is not possible: minimum is one dump cycle per instruction.
- EXEC lasts at most RETIRE_TIMEOUT+1 cycles.
- `do_write` stays high until `tx_ready` is seen high. DUMP_WAIT holds indefinitely until `tx_fall`.

## Test plan
- **Reset dump:** release `rst` with `tx_ready` low; model raises `tx_ready` 3 cycles later and drops it 40 later → `do_write` high until `tx_ready` rises, then FSM in IDLE, `count` 0.
- **Single instruction:** push 0x00500093, `instr_ready` held 1 → `instr_valid` 2 cycles after the edge with `instr_out` 0x00500093. A `retired` pulse 5 cycles later → `do_write` the next cycle; `count` 0.
- **Ordering/wrap:** push 0x11111111..0x66666666 (6 words, DEPTH 4), each dumped between issues → output order preserved across pointer wrap.
- **Overflow:** hold `instr_ready` 0, push 5 words → `count` 4, `overflow` 1, fifth word never issued. Then push 0xAAAAAAAA in the same cycle as a pop → accepted, `count` stays 4.
- **Timeout:** RETIRE_TIMEOUT=8, issue, no `retired` → `timeout` set and DUMP_REQ exactly 9 cycles after the accept. Repeat with `retired` on the timer==0 cycle → `timeout` stays 0.
- **Reset mid-dump:** assert `rst` in DUMP_WAIT with 2 words queued and `instruction_rcv` held high → after reset `count` 0, FSM in DUMP_REQ, no spurious push.
